// File: rtl/bitserial_shift_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bitserial_shift_acc                                               |
// | Shift-accumulates bit-serial partial products into per-weight products,    |
// | sums DOT_LEN products into a dot-product result and presents it on a       |
// | valid/ready output register. in_ready stalls the upstream MAC.             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module bitserial_shift_acc #(
  parameter int ACC_W   = 20,
  parameter int DOT_LEN = 4,
  parameter int CNT_W   = $clog2(DOT_LEN + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       wa,
  input  logic [2:0]       bit_idx,
  input  logic [1:0]       prec,
  input  logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  typedef enum logic [0:0] {
    S_ACCUM = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DOT_LEN - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_psum;
  logic [15:0]      w_psum_nxt;
  logic [15:0]      w_shifted;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf_acc;
  logic [CNT_W-1:0] r_prod_cnt;
  logic [ACC_W-1:0] r_out_data;
  logic             r_out_ovf;
  logic [2:0]       w_mask;
  logic [2:0]       w_sh;
  logic             w_accept;
  logic             w_prod_done;
  logic             w_final;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf_nxt;

  // Bit position within the current weight segment depends on precision.
  always_comb begin
    w_mask = 3'd7;
    case (prec)
      2'b00:   w_mask = 3'd7;
      2'b01:   w_mask = 3'd3;
      2'b10:   w_mask = 3'd1;
      default: w_mask = 3'd3;
    endcase
  end

  assign w_sh        = bit_idx & w_mask;
  assign w_shifted   = {8'b0, wa} << w_sh;
  // A beat at segment position 0 starts a fresh product, so no explicit clear.
  assign w_psum_nxt  = (w_sh == 3'd0) ? w_shifted : (r_psum + w_shifted);

  assign out_valid   = (r_state == S_FULL);
  assign in_ready    = ~out_valid | out_ready;
  assign w_accept    = in_valid & in_ready;
  assign w_prod_done = w_accept & done;
  assign w_final     = w_prod_done & (r_prod_cnt == c_last_cnt);

  assign w_sum       = {1'b0, r_acc} + {{(ACC_W + 1 - 16){1'b0}}, w_psum_nxt};
  assign w_ovf_nxt   = r_ovf_acc | w_sum[ACC_W];

  assign out_data    = r_out_data;
  assign out_ovf     = r_out_ovf;

  // Output-register occupancy state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_ACCUM;
    end else if (clr) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Full while a result waits; a completion during a handshake keeps it full.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACCUM: if (w_final) w_state_nxt = S_FULL;
      S_FULL:  if (out_ready && !w_final) w_state_nxt = S_ACCUM;
      default: w_state_nxt = S_ACCUM;
    endcase
  end

  // Partial-product, dot-product and output-register datapath.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_psum     <= '0;
      r_acc      <= '0;
      r_ovf_acc  <= 1'b0;
      r_prod_cnt <= '0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
    end else if (clr) begin
      r_psum     <= '0;
      r_acc      <= '0;
      r_ovf_acc  <= 1'b0;
      r_prod_cnt <= '0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_psum <= w_psum_nxt;
      if (w_prod_done) begin
        if (r_prod_cnt == c_last_cnt) begin
          r_out_data <= w_sum[ACC_W-1:0];
          r_out_ovf  <= w_ovf_nxt;
          r_acc      <= '0;
          r_ovf_acc  <= 1'b0;
          r_prod_cnt <= '0;
        end else begin
          r_acc      <= w_sum[ACC_W-1:0];
          r_ovf_acc  <= w_ovf_nxt;
          r_prod_cnt <= r_prod_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bitserial_shift_acc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_bitserial_shift_acc                                            |
// | Directed bench for bitserial_shift_acc: a 20-bit and a 16-bit instance     |
// | share stimulus; a product-level model predicts results every cycle.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_bitserial_shift_acc;

  localparam int DOT_LEN = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clr;
  logic        in_valid;
  logic [7:0]  wa;
  logic [2:0]  bit_idx;
  logic [1:0]  prec;
  logic        done;
  logic        out_ready;
  logic        in_ready, out_valid, out_ovf;
  logic [19:0] out_data;
  logic        in_ready16, out_valid16, out_ovf16;
  logic [15:0] out_data16;

  int nchecks = 0;
  int nerr    = 0;

  // Products of weight segments issued but not yet consumed by the model.
  longint prodq[$];
  // Results observed on DUT handshakes.
  longint got20_d[$], got20_o[$], got16_d[$], got16_o[$];

  // Model state: running true (unbounded) sum of products and held result.
  longint m_total;
  int     m_cnt;
  bit     m_valid;
  longint m_res;
  bit     m_take;

  bitserial_shift_acc #(.ACC_W(20), .DOT_LEN(DOT_LEN)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .wa(wa), .bit_idx(bit_idx), .prec(prec), .done(done), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  bitserial_shift_acc #(.ACC_W(16), .DOT_LEN(DOT_LEN)) dut16 (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_ready(in_ready16),
    .wa(wa), .bit_idx(bit_idx), .prec(prec), .done(done), .out_valid(out_valid16),
    .out_ready(out_ready), .out_data(out_data16), .out_ovf(out_ovf16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare then advance the model using the inputs the next edge will sample.
  initial begin
    m_total = 0; m_cnt = 0; m_valid = 0; m_res = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_total = 0; m_cnt = 0; m_valid = 0; prodq.delete();
      end else begin
        chk("in_ready",     in_ready,    logic'(!m_valid || out_ready));
        chk("out_valid",    out_valid,   m_valid);
        chk("in_ready16",   in_ready16,  logic'(!m_valid || out_ready));
        chk("out_valid16",  out_valid16, m_valid);
        if (m_valid) begin
          chk("out_data",   out_data,    m_res % (64'd1 << 20));
          chk("out_ovf",    out_ovf,     logic'(m_res >= (64'd1 << 20)));
          chk("out_data16", out_data16,  m_res % (64'd1 << 16));
          chk("out_ovf16",  out_ovf16,   logic'(m_res >= (64'd1 << 16)));
        end
        if (out_valid && out_ready) begin
          got20_d.push_back(out_data);   got20_o.push_back(out_ovf);
          got16_d.push_back(out_data16); got16_o.push_back(out_ovf16);
        end
        if (clr) begin
          m_total = 0; m_cnt = 0; m_valid = 0; prodq.delete();
        end else begin
          m_take = in_valid && (!m_valid || out_ready);
          if (m_valid && out_ready) m_valid = 0;
          if (m_take && done) begin
            if (prodq.size() == 0) begin
              nchecks++; nerr++;
              $display("FAIL model_underflow: got done beat expected none at %0t", $time);
            end else begin
              m_total += prodq.pop_front();
            end
            m_cnt++;
            if (m_cnt == DOT_LEN) begin
              m_res = m_total; m_valid = 1; m_total = 0; m_cnt = 0;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] a, input logic [2:0] idx, input logic [1:0] p,
                           input logic d);
    int n = 0;
    in_valid = 1'b1; wa = a; bit_idx = idx; prec = p; done = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        nchecks++; nerr++;
        $display("FAIL beat_timeout: got in_ready 0 expected 1 within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; done = 1'b0;
  endtask

  // Sends nb beats of weight byte w (LSB first) against activation a.
  task automatic send_weight(input logic [7:0] a, input logic [7:0] w, input logic [1:0] p,
                             input int nb);
    int  mask;
    bit  d;
    longint seg;
    mask = (p == 2'b00) ? 7 : (p == 2'b10) ? 1 : 3;
    for (int i = 0; i < nb; i++) begin
      d = ((i & mask) == mask);
      if (d) begin
        seg = (longint'(w) >> (i - mask)) & ((longint'(1) << (mask + 1)) - 1);
        prodq.push_back(longint'(a) * seg);
      end
      send_beat(a & {8{w[i]}}, 3'(i), p, d);
    end
  endtask

  task automatic run_dot(input logic [7:0] a, input logic [7:0] w, input logic [1:0] p,
                         input int nweights);
    for (int k = 0; k < nweights; k++) send_weight(a, w, p, 8);
  endtask

  task automatic expect_res(input string name, input longint e20, input bit o20,
                            input longint e16, input bit o16);
    if (got20_d.size() == 0 || got16_d.size() == 0) begin
      nchecks++; nerr++;
      $display("FAIL %s: got no result expected %0d", name, e20);
    end else begin
      chk({name, "_d20"}, got20_d.pop_front(), e20);
      chk({name, "_o20"}, got20_o.pop_front(), o20);
      chk({name, "_d16"}, got16_d.pop_front(), e16);
      chk({name, "_o16"}, got16_o.pop_front(), o16);
    end
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; in_valid = 1'b0; wa = '0; bit_idx = '0; prec = '0;
    done = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_ovf",   out_ovf,   0);
    chk("rst_out_data16", out_data16, 0);
    rstn = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 1);

    // 8-bit weights: 4 x (11*9)
    run_dot(8'h0B, 8'h09, 2'b00, 4);
    repeat (2) step();
    expect_res("c1", 396, 0, 396, 0);

    // 4-bit weights: 88,143,88,143
    run_dot(8'h0B, 8'hD8, 2'b01, 2);
    repeat (2) step();
    expect_res("c2", 462, 0, 462, 0);

    // 2-bit weights: 0,22,11,33
    run_dot(8'h0B, 8'hD8, 2'b10, 1);
    repeat (2) step();
    expect_res("c3", 66, 0, 66, 0);

    // prec=11 behaves as 4-bit
    run_dot(8'h0B, 8'hD8, 2'b11, 2);
    repeat (2) step();
    expect_res("c3b", 462, 0, 462, 0);

    // Overflow boundary: 4 x 65025 wraps the 16-bit instance only
    run_dot(8'hFF, 8'hFF, 2'b00, 4);
    repeat (2) step();
    expect_res("c5", 260100, 0, 63492, 1);
    run_dot(8'h0B, 8'h09, 2'b00, 4);
    repeat (2) step();
    expect_res("c5n", 396, 0, 396, 0);

    // Backpressure: result held while a second dot product waits upstream
    out_ready = 1'b0;
    run_dot(8'h0B, 8'h09, 2'b00, 4);
    fork
      run_dot(8'h0B, 8'hD8, 2'b01, 2);
      begin
        for (int c = 0; c < 10; c++) begin
          step();
          chk("bp_in_ready", in_ready, 0);
          chk("bp_hold",     out_data, 396);
        end
        out_ready = 1'b1;
      end
    join
    repeat (2) step();
    expect_res("c4a", 396, 0, 396, 0);
    expect_res("c4b", 462, 0, 462, 0);

    // Async reset mid-dot and mid-segment
    send_weight(8'h0B, 8'h09, 2'b00, 8);
    send_weight(8'h0B, 8'h09, 2'b00, 5);
    rstn = 1'b0;
    step();
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_data",  out_data,  0);
    rstn = 1'b1;
    step();
    run_dot(8'h0B, 8'h09, 2'b00, 4);
    repeat (2) step();
    expect_res("c6r", 396, 0, 396, 0);

    // Synchronous clear with a concurrent done beat, which must be dropped
    send_weight(8'h0B, 8'h09, 2'b00, 8);
    send_weight(8'h0B, 8'h09, 2'b00, 5);
    clr = 1'b1; in_valid = 1'b1; wa = 8'h0B; bit_idx = 3'd7; prec = 2'b00; done = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0; done = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_out_data",  out_data,  0);
    chk("clr_out_ovf",   out_ovf,   0);
    chk("clr_in_ready",  in_ready,  1);
    run_dot(8'h0B, 8'h09, 2'b00, 4);
    repeat (2) step();
    expect_res("c6c", 396, 0, 396, 0);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
